// File: rtl/ofs_pkg.sv
// Shared constants and forwarding-tag type for the operand fetch stage.
package ofs_pkg;

   localparam logic [3:0] REG_PC     = 4'd15;
   localparam int         DEF_DW     = 32;
   localparam int         DEF_CTRL_W = 16;
   localparam int         DEF_PC_OFS = 8;

   typedef struct packed {
      logic       vld;
      logic       wr;
      logic [3:0] rd;
   } fwd_tag_t;

   // A producer writing R15 never forwards: R15 reads always see the PC.
   function automatic logic tag_hit(fwd_tag_t t, logic [3:0] rs);
      return t.vld && t.wr && (t.rd == rs) && (t.rd != REG_PC);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// One operand's source mux: PC+ofs for R15, else youngest EX/MEM/WB hit, else register file.
// Purely combinational; also flags a not-yet-available load result in EX.
module fwd_select
   import ofs_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int PC_OFS = DEF_PC_OFS
) (
   input  logic [3:0]    rs_i,
   input  logic          use_i,
   input  logic [DW-1:0] pc_i,
   input  logic [DW-1:0] rf_dat_i,
   input  fwd_tag_t      ex_tag_i,
   input  logic          ex_load_i,
   input  logic [DW-1:0] ex_dat_i,
   input  fwd_tag_t      mem_tag_i,
   input  logic [DW-1:0] mem_dat_i,
   input  fwd_tag_t      wb_tag_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] op_o,
   output logic          load_hit_o
);

   always_comb begin
      op_o       = rf_dat_i;
      load_hit_o = 1'b0;
      if (rs_i == REG_PC) begin
         op_o = pc_i + DW'(PC_OFS);
      end else if (tag_hit(ex_tag_i, rs_i) && !ex_load_i) begin
         op_o = ex_dat_i;
      end else if (tag_hit(mem_tag_i, rs_i)) begin
         op_o = mem_dat_i;
      end else if (tag_hit(wb_tag_i, rs_i)) begin
         op_o = wb_dat_i;
      end
      load_hit_o = use_i && (rs_i != REG_PC) && tag_hit(ex_tag_i, rs_i) && ex_load_i;
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX stage: resolves operands by forwarding, stalls on load-use, registers into ID/EX (1-cycle latency).
// Holds all state while EX withholds ex_ready; flush kills the register and drops the ID instruction.
module operand_fetch_stage
   import ofs_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int PC_OFS = DEF_PC_OFS,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [3:0]        id_ra,
   input  logic [3:0]        id_rb,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic [3:0]        id_rd,
   input  logic              id_wr,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DW-1:0]     id_pc,
   input  logic [DW-1:0]     rf_y0,
   input  logic [DW-1:0]     rf_y1,
   input  logic              ex_fwd_valid,
   input  logic              ex_fwd_wr,
   input  logic              ex_fwd_load,
   input  logic [3:0]        ex_fwd_rd,
   input  logic [DW-1:0]     ex_fwd_data,
   input  logic              mem_fwd_valid,
   input  logic              mem_fwd_wr,
   input  logic [3:0]        mem_fwd_rd,
   input  logic [DW-1:0]     mem_fwd_data,
   input  logic              wb_fwd_valid,
   input  logic              wb_fwd_wr,
   input  logic [3:0]        wb_fwd_rd,
   input  logic [DW-1:0]     wb_fwd_data,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [DW-1:0]     ex_op_a,
   output logic [DW-1:0]     ex_op_b,
   output logic [3:0]        ex_rd,
   output logic              ex_wr,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DW-1:0]     ex_pc,
   output logic [CNT_W-1:0]  stall_cnt
);

   fwd_tag_t          ex_tag, mem_tag, wb_tag;
   logic [DW-1:0]     op_a, op_b;
   logic              hit_a, hit_b, hz, adv, load_en;
   logic              ex_valid_q, ex_valid_d;
   logic [DW-1:0]     op_a_q, op_b_q, pc_q;
   logic [3:0]        rd_q;
   logic              wr_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign ex_tag  = {ex_fwd_valid, ex_fwd_wr, ex_fwd_rd};
   assign mem_tag = {mem_fwd_valid, mem_fwd_wr, mem_fwd_rd};
   assign wb_tag  = {wb_fwd_valid, wb_fwd_wr, wb_fwd_rd};

   fwd_select #(.DW(DW), .PC_OFS(PC_OFS)) u_sel_a (
      .rs_i(id_ra), .use_i(id_use_a), .pc_i(id_pc), .rf_dat_i(rf_y0),
      .ex_tag_i(ex_tag), .ex_load_i(ex_fwd_load), .ex_dat_i(ex_fwd_data),
      .mem_tag_i(mem_tag), .mem_dat_i(mem_fwd_data),
      .wb_tag_i(wb_tag), .wb_dat_i(wb_fwd_data),
      .op_o(op_a), .load_hit_o(hit_a)
   );

   fwd_select #(.DW(DW), .PC_OFS(PC_OFS)) u_sel_b (
      .rs_i(id_rb), .use_i(id_use_b), .pc_i(id_pc), .rf_dat_i(rf_y1),
      .ex_tag_i(ex_tag), .ex_load_i(ex_fwd_load), .ex_dat_i(ex_fwd_data),
      .mem_tag_i(mem_tag), .mem_dat_i(mem_fwd_data),
      .wb_tag_i(wb_tag), .wb_dat_i(wb_fwd_data),
      .op_o(op_b), .load_hit_o(hit_b)
   );

   assign hz       = id_valid && (hit_a || hit_b);
   assign adv      = !ex_valid_q || ex_ready;
   assign id_ready = flush || (adv && !hz);

   always_comb begin
      ex_valid_d  = ex_valid_q;
      load_en     = 1'b0;
      stall_cnt_d = stall_cnt_q;
      if (adv || flush) begin
         ex_valid_d = id_valid && !hz && !flush;
         load_en    = ex_valid_d;
      end
      // Counts while stalled even if EX is also back-pressuring; saturates.
      if (hz && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         ex_valid_q  <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rd_q        <= '0;
         wr_q        <= 1'b0;
         ctrl_q      <= '0;
         pc_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         stall_cnt_q <= stall_cnt_d;
         if (load_en) begin
            op_a_q <= op_a;
            op_b_q <= op_b;
            rd_q   <= id_rd;
            wr_q   <= id_wr;
            ctrl_q <= id_ctrl;
            pc_q   <= id_pc;
         end
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_op_a   = op_a_q;
   assign ex_op_b   = op_b_q;
   assign ex_rd     = rd_q;
   assign ex_wr     = wr_q;
   assign ex_ctrl   = ctrl_q;
   assign ex_pc     = pc_q;
   assign stall_cnt = stall_cnt_q;

endmodule
